// File: rtl/mem_bank_router.sv
`default_nettype none
// ============================================================================
// Module      : mem_bank_router
// Description : N-bank address router between the AXI4-Lite memory-interface
//               bridge and the memory banks. A configurable address field
//               selects the bank; requests are forwarded combinationally.
//               Outstanding reads are tracked in an in-order tag FIFO so each
//               response is taken from the bank addressed at issue time.
//               Unmapped reads return ERR_DATA; unmapped writes are dropped.
//               Optional error logging is compiled in with the macro
//               ROUTER_ERR_LOG_EN (adds err_clr/err_valid/err_addr/err_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bank_router #(
  parameter int          NUM_BANKS       = 4,
  parameter int          ADDR_WIDTH      = 16,
  parameter int          DATA_WIDTH      = 32,
  parameter int          SEL_LSB         = 12,
  parameter int          SEL_BITS        = 4,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] ERR_DATA        = 32'hDEAD_BEEF
) (
  input  logic                            clk_a,
  input  logic                            arstz_aq,
  input  logic                            host_en,
  input  logic                            host_we,
  input  logic [ADDR_WIDTH-1:0]           host_addr,
  input  logic [DATA_WIDTH-1:0]           host_din,
  output logic                            host_ready,
  output logic [DATA_WIDTH-1:0]           host_dout,
  output logic                            host_valid,
  output logic [NUM_BANKS-1:0]            bank_en,
  output logic [NUM_BANKS-1:0]            bank_we,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_din,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_dout,
  input  logic [NUM_BANKS-1:0]            bank_valid
`ifdef ROUTER_ERR_LOG_EN
  ,
  input  logic                            err_clr,
  output logic                            err_valid,
  output logic [ADDR_WIDTH-1:0]           err_addr,
  output logic [7:0]                      err_cnt
`endif
);

  // Tag FIFO geometry: depth is a power of two so pointers wrap naturally.
  localparam int                      c_ptr_w    = $clog2(MAX_OUTSTANDING);
  localparam int                      c_cnt_w    = c_ptr_w + 1;
  localparam int                      c_tag_w    = SEL_BITS + 1;
  localparam logic [c_cnt_w-1:0]      c_full     = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [DATA_WIDTH-1:0]   c_err_data = DATA_WIDTH'(ERR_DATA);

  // --------------------------------------------------------------------------
  // Address decode and accept
  // --------------------------------------------------------------------------
  logic [SEL_BITS-1:0] w_idx;
  logic                w_mapped;
  logic                w_acc;
  logic                w_push;
  logic                w_pop;

  logic [c_cnt_w-1:0]  r_count;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_tag_w-1:0]  r_tag_mem [MAX_OUTSTANDING];

  logic [c_tag_w-1:0]  w_head_tag;
  logic                w_head_err;
  logic [SEL_BITS-1:0] w_head_bank;
  logic                w_head_bank_valid;
  logic [DATA_WIDTH-1:0] w_head_dout;

  logic                  r_host_valid;
  logic [DATA_WIDTH-1:0] r_host_dout;

  assign w_idx      = host_addr[SEL_LSB +: SEL_BITS];
  assign w_mapped   = (32'(w_idx) < 32'(NUM_BANKS));

  // Backpressure is based on the registered count only; a pop in the same
  // cycle does not free a slot until the next cycle.
  assign host_ready = (r_count < c_full);
  assign w_acc      = host_en & host_ready;
  assign w_push     = w_acc & ~host_we;

  // --------------------------------------------------------------------------
  // Combinational per-bank forwarding
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic w_hit;
      assign w_hit = w_mapped & (w_idx == SEL_BITS'(gi));
      assign bank_en[gi] = w_acc & w_hit;
      assign bank_we[gi] = w_acc & w_hit & host_we;
      assign bank_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = w_hit ? host_addr : '0;
      assign bank_din[gi*DATA_WIDTH +: DATA_WIDTH]  = w_hit ? host_din  : '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Head-of-FIFO response selection
  // --------------------------------------------------------------------------
  assign w_head_tag  = r_tag_mem[r_rd_ptr];
  assign w_head_err  = w_head_tag[SEL_BITS];
  assign w_head_bank = w_head_tag[SEL_BITS-1:0];

  // Select valid/data of the bank named by the head tag; other banks' valids
  // are out-of-order responses and are simply not looked at.
  always_comb begin
    w_head_bank_valid = 1'b0;
    w_head_dout       = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (w_head_bank == SEL_BITS'(i)) begin
        w_head_bank_valid = bank_valid[i];
        w_head_dout       = bank_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Error tags retire immediately at the head; mapped tags wait for their bank.
  assign w_pop = (r_count != '0) & (w_head_err | w_head_bank_valid);

  // --------------------------------------------------------------------------
  // Tag FIFO storage and pointers
  // --------------------------------------------------------------------------
  // Tag write on read accept: error flag plus bank index captured at issue.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tag_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_tag_mem[r_wr_ptr] <= {~w_mapped, w_idx};
    end
  end

  // Pointer and occupancy update; simultaneous push and pop keep the count.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered host response
  // --------------------------------------------------------------------------
  // One-cycle valid pulse per retired tag; data holds between pulses.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      r_host_valid <= 1'b0;
      r_host_dout  <= '0;
    end else begin
      r_host_valid <= w_pop;
      if (w_pop) begin
        r_host_dout <= w_head_err ? c_err_data : w_head_dout;
      end
    end
  end

  assign host_valid = r_host_valid;
  assign host_dout  = r_host_dout;

`ifdef ROUTER_ERR_LOG_EN
  // --------------------------------------------------------------------------
  // Unmapped-access error log
  // --------------------------------------------------------------------------
  logic                  w_err_hit;
  logic                  r_err_valid;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [7:0]            r_err_cnt;

  assign w_err_hit = w_acc & ~w_mapped;

  // Sticky first-error capture and saturating counter; clear has priority.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_cnt   <= '0;
    end else if (err_clr) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_cnt   <= '0;
    end else if (w_err_hit) begin
      if (!r_err_valid) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= host_addr;
      end
      if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
  assign err_cnt   = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bank_router
// Description : Self-checking bench for mem_bank_router (default parameters).
//               A queue-based reference model of outstanding reads predicts
//               forwarding, backpressure and response timing; a scoreboard
//               monitor checks returned data in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bank_router;

  localparam int          NB   = 4;
  localparam int          AW   = 16;
  localparam int          DW   = 32;
  localparam int          MAXO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic               clk_a;
  logic               arstz_aq;
  logic               host_en;
  logic               host_we;
  logic [AW-1:0]      host_addr;
  logic [DW-1:0]      host_din;
  logic               host_ready;
  logic [DW-1:0]      host_dout;
  logic               host_valid;
  logic [NB-1:0]      bank_en;
  logic [NB-1:0]      bank_we;
  logic [NB*AW-1:0]   bank_addr;
  logic [NB*DW-1:0]   bank_din;
  logic [NB*DW-1:0]   bank_dout;
  logic [NB-1:0]      bank_valid;
`ifdef ROUTER_ERR_LOG_EN
  logic               err_clr;
  logic               err_valid;
  logic [AW-1:0]      err_addr;
  logic [7:0]         err_cnt;
`endif

  mem_bank_router dut (
    .clk_a      (clk_a),
    .arstz_aq   (arstz_aq),
    .host_en    (host_en),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_din   (host_din),
    .host_ready (host_ready),
    .host_dout  (host_dout),
    .host_valid (host_valid),
    .bank_en    (bank_en),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_din   (bank_din),
    .bank_dout  (bank_dout),
    .bank_valid (bank_valid)
`ifdef ROUTER_ERR_LOG_EN
    ,
    .err_clr    (err_clr),
    .err_valid  (err_valid),
    .err_addr   (err_addr),
    .err_cnt    (err_cnt)
`endif
  );

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  typedef struct {
    bit          err;
    int          bank;
    logic [31:0] data;
  } tag_t;

  tag_t        pend[$];   // outstanding reads, oldest first
  logic [31:0] sb[$];     // expected host_dout values, in order
  int          checks   = 0;
  int          failures = 0;
  bit          exp_hv   = 1'b0;
  bit          m_ev     = 1'b0;
  logic [15:0] m_ea     = '0;
  int          m_cnt    = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk_a) begin
    if (arstz_aq && host_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_host_valid actual=%0h expected=none t=%0t", host_dout, $time);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("host_dout", host_dout, e);
      end
    end
  end

  // One clock of stimulus plus model update. resp: let the head bank answer.
  // spur: bank index to raise a spurious (non-head) valid on, or -1.
  task automatic cycle(input bit en, input bit we, input logic [15:0] addr,
                       input logic [31:0] din, input bit resp, input int spur);
    int          idx;
    bit          mapped, rdy, acc, pop;
    logic [3:0]  e_en, e_we;
    logic [63:0] e_addr;
    logic [127:0] e_din;
    tag_t        t;
    @(posedge clk_a); #1;
    host_en = en; host_we = we; host_addr = addr; host_din = din;
    bank_valid = '0;
    for (int i = 0; i < NB; i++) bank_dout[i*DW +: DW] = $urandom;
    pop = 1'b0;
    if (pend.size() != 0) begin
      if (pend[0].err) pop = 1'b1;
      else if (resp) begin
        bank_valid[pend[0].bank] = 1'b1;
        bank_dout[pend[0].bank*DW +: DW] = pend[0].data;
        pop = 1'b1;
      end
    end
    if (spur >= 0 && spur < NB) begin
      if (pend.size() == 0) bank_valid[spur] = 1'b1;
      else if (pend[0].err || pend[0].bank != spur) bank_valid[spur] = 1'b1;
    end

    @(negedge clk_a);
    chk("host_valid", host_valid, exp_hv);
    idx    = int'(addr[15:12]);
    mapped = (idx < NB);
    rdy    = (pend.size() < MAXO);
    acc    = en && rdy;
    chk("host_ready", host_ready, rdy);
    e_en = (acc && mapped) ? 4'(1 << idx) : 4'b0;
    e_we = we ? e_en : 4'b0;
    e_addr = '0;
    e_din  = '0;
    if (mapped) begin
      e_addr[idx*AW +: AW] = addr;
      e_din[idx*DW +: DW]  = din;
    end
    chk("bank_en", bank_en, e_en);
    chk("bank_we", bank_we, e_we);
    chk("bank_addr", bank_addr, e_addr);
    chk("bank_din", bank_din, e_din);
`ifdef ROUTER_ERR_LOG_EN
    chk("err_valid", err_valid, m_ev);
    chk("err_addr", err_addr, m_ea);
    chk("err_cnt", err_cnt, m_cnt);
    if (err_clr) begin
      m_ev = 1'b0; m_ea = '0; m_cnt = 0;
    end else if (acc && !mapped) begin
      if (!m_ev) begin m_ev = 1'b1; m_ea = addr; end
      if (m_cnt < 255) m_cnt++;
    end
`endif
    if (pop) void'(pend.pop_front());
    if (acc && !we) begin
      t.err  = !mapped;
      t.bank = idx;
      t.data = $urandom;
      pend.push_back(t);
      sb.push_back(t.err ? ERRD : t.data);
    end
    exp_hv = pop;
  endtask

  task automatic do_reset();
    @(posedge clk_a); #1;
    arstz_aq = 1'b0; host_en = 1'b0; bank_valid = '0;
    pend.delete(); sb.delete(); exp_hv = 1'b0;
    m_ev = 1'b0; m_ea = '0; m_cnt = 0;
    @(negedge clk_a);
    chk("rst_host_valid", host_valid, 1'b0);
    chk("rst_host_ready", host_ready, 1'b1);
    @(posedge clk_a); #1;
    arstz_aq = 1'b1;
  endtask

  task automatic idle(input int n, input bit resp);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 32'h0, resp, -1);
  endtask

  initial begin
    arstz_aq = 1'b0; host_en = 1'b0; host_we = 1'b0;
    host_addr = '0; host_din = '0; bank_dout = '0; bank_valid = '0;
`ifdef ROUTER_ERR_LOG_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk_a);
    #1 arstz_aq = 1'b1;
    @(negedge clk_a);
    chk("init_host_valid", host_valid, 1'b0);
    chk("init_host_ready", host_ready, 1'b1);
    chk("init_host_dout", host_dout, 32'h0);

`ifdef ROUTER_ERR_LOG_EN
    // Two unmapped writes, then clear.
    cycle(1'b1, 1'b1, 16'h7000, 32'h1, 1'b0, -1);
    cycle(1'b1, 1'b1, 16'h9000, 32'h2, 1'b0, -1);
    idle(1, 1'b1);
    chk("err_valid_set", err_valid, 1'b1);
    chk("err_addr_first", err_addr, 16'h7000);
    chk("err_cnt_two", err_cnt, 8'd2);
    err_clr = 1'b1;
    idle(1, 1'b1);
    err_clr = 1'b0;
    idle(1, 1'b1);
    chk("err_cnt_clr", err_cnt, 8'd0);
`endif

    // Mapped write to bank 1.
    cycle(1'b1, 1'b1, 16'h1004, 32'hA5A5_A5A5, 1'b0, -1);
    idle(1, 1'b0);

    // Read bank 2; bank answers 3 cycles later while the address has moved.
    cycle(1'b1, 1'b0, 16'h2000, 32'h0, 1'b0, -1);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Unmapped read returns the error word one cycle later.
    cycle(1'b1, 1'b0, 16'h5000, 32'h0, 1'b0, -1);
    idle(2, 1'b0);

    // Fill the tag FIFO with bank-3 reads; the fifth is held.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'h3000 + 16'(i), 32'h0, 1'b0, -1);
    cycle(1'b1, 1'b0, 16'h3005, 32'h0, 1'b1, -1);
    cycle(1'b1, 1'b0, 16'h3005, 32'h0, 1'b0, -1);
    idle(6, 1'b1);

    // Spurious valid from bank 1 while bank 0 is the head.
    cycle(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, -1);
    cycle(1'b1, 1'b0, 16'h5000, 32'h0, 1'b0, 1);
    cycle(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1);
    idle(3, 1'b1);

    // Reset with reads outstanding; a late bank answer must be ignored.
    cycle(1'b1, 1'b0, 16'h2100, 32'h0, 1'b0, -1);
    cycle(1'b1, 1'b0, 16'h2200, 32'h0, 1'b0, -1);
    do_reset();
    cycle(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 2);
    idle(2, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a;
      int          s;
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a[15:12] = 4'($urandom_range(4, 15));
      else                            a[15:12] = 4'($urandom_range(0, 3));
      s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a,
            32'($urandom), ($urandom_range(0, 2) != 0), s);
    end
    idle(12, 1'b1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bank_router.md
Name: mem_bank_router

Overview:
Parametrised N-bank address router between the AXI4-Lite memory-interface bridge and the register/input/weight/feature memory banks.
- Decodes a configurable address field to select a bank and forwards requests.
- Tracks outstanding reads in an in-order tag FIFO, so each read response comes from the bank addressed at issue time, not the current address.
- Generates a fixed error response for unmapped reads and applies backpressure when the tag FIFO is full.

Parameters:
NUM_BANKS, 4, number of downstream banks (1..16)
ADDR_WIDTH, 16, address width
DATA_WIDTH, 32, data width
SEL_LSB, 12, LSB of bank-select field in host_addr
SEL_BITS, 4, width of bank-select field; requires 2**SEL_BITS >= NUM_BANKS
MAX_OUTSTANDING, 4, tag FIFO depth (power of two, >=2)
ERR_DATA, 32'hDEAD_BEEF, dout returned for unmapped reads (truncated/zero-extended to DATA_WIDTH)

Ports:
clk_a  in  1  clock
arstz_aq  in  1  asynchronous active-low reset
host_en  in  1  request strobe
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_WIDTH  request address
host_din  in  DATA_WIDTH  write data
host_ready  out  1  request accepted when host_en & host_ready
host_dout  out  DATA_WIDTH  read data
host_valid  out  1  read data valid, one-cycle pulse
bank_en  out  NUM_BANKS  per-bank enable
bank_we  out  NUM_BANKS  per-bank write enable
bank_addr  out  NUM_BANKS*ADDR_WIDTH  per-bank address, bank i at slice i
bank_din  out  NUM_BANKS*DATA_WIDTH  per-bank write data
bank_dout  in  NUM_BANKS*DATA_WIDTH  per-bank read data
bank_valid  in  NUM_BANKS  per-bank read data valid

Behaviour:
- Single clock clk_a. Reset arstz_aq is asynchronous, active-low.
- Decode: idx = host_addr[SEL_LSB +: SEL_BITS]; mapped = idx < NUM_BANKS.
- Accept: acc = host_en & host_ready.
- host_ready = (tag count < MAX_OUTSTANDING). It is registered-count based; there is no same-cycle pop bypass.
- Forwarding is combinational, zero added latency.
  - bank_en[i] = acc & mapped & (idx==i); bank_we[i] = bank_en[i] & host_we.
  - bank_addr/bank_din slice i = host value when idx==i & mapped, else 0.
- Writes never push a tag and produce no host_valid.
- Unmapped writes are dropped: no bank enabled, no response.
- Read accept pushes a tag: {err=~mapped, bank=idx}.
- Response, mapped head tag:
  - When bank_valid[head.bank]=1, register host_dout=bank_dout slice and host_valid=1 on the next edge, then pop.
  - Latency: bank_valid at cycle t -> host_valid at t+1.
- Response, error head tag: at the first cycle it is head, register host_dout=ERR_DATA and host_valid=1, then pop. Latency is one cycle after it becomes head.
- bank_valid from any bank other than the head bank, or with the FIFO empty, is ignored (protocol violation).
- Banks must respond in issue order. Responses stay strictly in order.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- host_valid deasserts the cycle after each pulse unless another pop occurs.
- Pointers wrap modulo MAX_OUTSTANDING.
- Count range is 0..MAX_OUTSTANDING; when full, host_ready=0 and no push occurs even if host_en=1.
- Reset values: host_valid=0, host_dout=0, tag count=0, pointers=0, host_ready=1 after reset.
- Reset mid-operation discards all pending tags. Bank responses arriving after reset release are ignored because the FIFO is empty.

Optional Feature:
Macro ROUTER_ERR_LOG_EN.
- Defined: extra ports err_clr (in, 1), err_valid (out, 1), err_addr (out, ADDR_WIDTH), err_cnt (out, 8).
  - The first accepted unmapped access (read or write) sets err_valid and captures host_addr into err_addr. Both stay sticky until err_clr.
  - err_cnt increments, saturating at 255, on every accepted unmapped access.
  - err_clr zeroes all three. If an error and err_clr occur in the same cycle, clear wins.
  - All three reset to 0.
- Undefined: these ports and registers do not exist; routing behaviour is identical.

Test Plan:
- Write 0x1004 data 0xA5A5A5A5 -> bank_en=4'b0010, bank_we=4'b0010, bank 1 addr=0x1004, din=0xA5A5A5A5; other slices 0; no host_valid.
- Read 0x2000; bank 2 returns valid 3 cycles later with 0x12345678 while host_addr has moved to 0x0000 -> host_valid one cycle after bank_valid, host_dout=0x12345678.
- Read 0x5000 (unmapped, NUM_BANKS=4) -> no bank_en; host_valid exactly one cycle later, host_dout=0xDEADBEEF.
- Issue 5 back-to-back reads to bank 3 without responses -> host_ready low after 4th accept, 5th held. First bank_valid -> host_ready high next cycle, 5th accepted. Responses returned in order.
- Read bank 0, then read unmapped; bank 1 asserts a spurious valid before bank 0 responds -> spurious valid ignored. host_valid carries bank 0 data, then ERR_DATA the following cycle.
- Two reads outstanding, assert arstz_aq low for 1 cycle -> host_valid=0, host_ready=1. Late bank_valid produces no host_valid.
- With ROUTER_ERR_LOG_EN: writes to 0x7000 then 0x9000 -> err_valid=1, err_addr=0x7000, err_cnt=2. err_clr -> all 0.
